// File: rtl/dadd_seq.sv
// dadd_seq: data-adder B-operand sequencer; optional Z steps enabled by DADD_SEQ_ZSTEP_EN
module dadd_seq #(
    parameter int CNT_W = 4
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_srcadd,
    input  logic             cmd_gourd,
    input  logic             cmd_gourz,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_abort,
    input  logic             dadd_stall,
    output logic             daddbsel_0,
    output logic             daddbsel_1,
    output logic             daddbsel_2,
    output logic             dadd_ld,
    output logic             dadd_cy,
    output logic [CNT_W-1:0] pass_idx,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, SRC, ILO, IHI, ZLO, ZHI, DRAIN} state_t;
    state_t state, first_st, acc_st, step_nxt;
    logic src_q, gd_q, gz_q, cmd_gz, is_step, pass_end, last;
    logic [CNT_W-1:0] cnt_q;
`ifdef DADD_SEQ_ZSTEP_EN
    assign cmd_gz = cmd_gourz;
    assign daddbsel_1 = state == ZLO || state == ZHI;
`else
    logic unused_gz;
    assign unused_gz = cmd_gourz;
    assign cmd_gz = 1'b0;
    assign daddbsel_1 = 1'b0;
`endif
    // step ordering: first step of a pass and successor of the current step
    always_comb begin
        first_st = src_q ? SRC : gd_q ? ILO : gz_q ? ZLO : DRAIN;
        acc_st   = cmd_srcadd ? SRC : cmd_gourd ? ILO : cmd_gz ? ZLO : DRAIN;
        step_nxt = (state == SRC && gd_q) ? ILO :
                   ((state == SRC || state == IHI) && gz_q) ? ZLO :
                   state == ILO ? IHI :
                   state == ZLO ? ZHI : IDLE;
        is_step  = state inside {SRC, ILO, IHI, ZLO, ZHI};
        pass_end = step_nxt == IDLE;
        last     = is_step && pass_end && pass_idx == cnt_q;
    end
    assign cmd_ready  = state == IDLE;
    assign daddbsel_2 = state inside {ILO, IHI, ZLO, ZHI};
    assign daddbsel_0 = state == IHI || state == ZHI;
    assign dadd_cy    = daddbsel_0;
    assign dadd_ld    = is_step && !dadd_stall && !cmd_abort;
    assign done       = !cmd_abort && (state == DRAIN || (last && !dadd_stall));
    // command acceptance, abort, stall hold and pass stepping
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= IDLE;
            pass_idx <= '0;
            src_q    <= 1'b0;
            gd_q     <= 1'b0;
            gz_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (state == IDLE) begin
            if (cmd_valid) begin
                state    <= acc_st;
                pass_idx <= '0;
                src_q    <= cmd_srcadd;
                gd_q     <= cmd_gourd;
                gz_q     <= cmd_gz;
                cnt_q    <= cmd_count;
            end
        end else if (cmd_abort || state == DRAIN) begin
            state <= IDLE;
        end else if (!dadd_stall) begin
            if (!pass_end) begin
                state <= step_nxt;
            end else if (pass_idx < cnt_q) begin
                pass_idx <= pass_idx + 1'b1;
                state    <= first_st;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dadd_seq.sv
// tb_dadd_seq: table, hand-written and randomized checks of dadd_seq against a step-list model
module tb_dadd_seq;
    logic sys_clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_ready;
    logic cmd_srcadd = 1'b0, cmd_gourd = 1'b0, cmd_gourz = 1'b0, cmd_abort = 1'b0, dadd_stall = 1'b0;
    logic [3:0] cmd_count = '0, pass_idx;
    logic daddbsel_0, daddbsel_1, daddbsel_2, dadd_ld, dadd_cy, done;
    int tests = 0, fails = 0;
`ifdef DADD_SEQ_ZSTEP_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    dadd_seq #(.CNT_W(4)) dut (
        .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_srcadd(cmd_srcadd), .cmd_gourd(cmd_gourd), .cmd_gourz(cmd_gourz),
        .cmd_count(cmd_count), .cmd_abort(cmd_abort), .dadd_stall(dadd_stall),
        .daddbsel_0(daddbsel_0), .daddbsel_1(daddbsel_1), .daddbsel_2(daddbsel_2),
        .dadd_ld(dadd_ld), .dadd_cy(dadd_cy), .pass_idx(pass_idx), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic s, g, z;
        logic [3:0] cnt;
        int len;
        logic [2:0] first_sel;
    } vec_t;

    function automatic logic [2:0] sel();
        return {daddbsel_2, daddbsel_1, daddbsel_0};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {cmd_ready, sel(), dadd_ld, dadd_cy, done}, {1'b1, 3'b000, 3'b000});
    endtask

    task automatic accept(input logic s, g, z, input logic [3:0] cnt, input logic ab);
        int w = 0;
        @(negedge sys_clk);
        while (!cmd_ready && w < 100) begin
            @(negedge sys_clk);
            w++;
        end
        cmd_srcadd = s; cmd_gourd = g; cmd_gourz = z; cmd_count = cnt;
        cmd_valid = 1'b1; cmd_abort = ab; dadd_stall = 1'b0;
        #1 chk("accept_ready", 16'(cmd_ready), 16'h1);
        @(negedge sys_clk);
        cmd_valid = 1'b0; cmd_abort = 1'b0;
    endtask

    task automatic count_len(input vec_t v, input int k);
        int n = 1;
        accept(v.s, v.g, v.z, v.cnt, 1'b0);
        #1 chk($sformatf("tbl%0d_first_sel", k), 16'(sel()), 16'(v.first_sel));
        while (!done && n < 100) begin
            @(negedge sys_clk);
            #1 n++;
        end
        chk($sformatf("tbl%0d_len", k), 16'(n), 16'(v.len));
    endtask

    task automatic run_cmd(input logic s, g, z, input logic [3:0] cnt, input int stall_pct,
                           input logic [31:0] stall_mask, input int abort_at, input string name);
        logic [2:0] steps[$];
        logic [2:0] seq[$];
        logic st, ab, ld;
        logic [10:0] exp;
        int i = 0, cyc = 0;
        if (s) steps.push_back(3'b000);
        if (g) begin steps.push_back(3'b100); steps.push_back(3'b101); end
        if (z && ZEN) begin steps.push_back(3'b110); steps.push_back(3'b111); end
        for (int p = 0; p <= int'(cnt); p++)
            foreach (steps[j]) seq.push_back(steps[j]);
        accept(s, g, z, cnt, 1'($urandom_range(1)));
        if (seq.size() == 0) begin
            ab = abort_at == 0;
            cmd_abort = ab;
            #1 chk({name, "_drain"}, {5'b0, cmd_ready, sel(), dadd_ld, dadd_cy, done, pass_idx},
                   {5'b0, 1'b0, 3'b000, 1'b0, 1'b0, !ab, 4'd0});
            @(negedge sys_clk);
        end
        while (i < seq.size() && cyc < 2000) begin
            st = stall_mask[cyc % 32] || $urandom_range(99) < stall_pct;
            ab = cyc == abort_at;
            dadd_stall = st; cmd_abort = ab;
            ld = !st && !ab;
            exp = {1'b0, seq[i], ld, seq[i][2] & seq[i][0], ld && i == seq.size() - 1,
                   4'(i / steps.size())};
            #1 chk($sformatf("%s_c%0d", name, cyc),
                   {5'b0, cmd_ready, sel(), dadd_ld, dadd_cy, done, pass_idx}, {5'b0, exp});
            @(negedge sys_clk);
            cyc++;
            if (ab) break;
            if (!st) i++;
        end
        dadd_stall = 1'b0; cmd_abort = 1'b0;
        #1 chk_idle({name, "_idle"});
    endtask

    initial begin
        vec_t tbl[7];
        logic [5:0] ld_v, rdy_v;
        tbl[0] = '{1, 1, 1, 4'd1,  ZEN ? 10 : 6, 3'b000};
        tbl[1] = '{0, 1, 0, 4'd0,  2, 3'b100};
        tbl[2] = '{0, 0, 0, 4'd5,  1, 3'b000};
        tbl[3] = '{0, 0, 1, 4'd0,  ZEN ? 2 : 1, ZEN ? 3'b110 : 3'b000};
        tbl[4] = '{1, 0, 0, 4'd15, 16, 3'b000};
        tbl[5] = '{0, 1, 1, 4'd2,  ZEN ? 12 : 6, 3'b100};
        tbl[6] = '{1, 0, 1, 4'd0,  ZEN ? 3 : 1, 3'b000};

        repeat (3) @(negedge sys_clk);
        #1 chk_idle("reset_during");
        reset = 1'b0;
        @(negedge sys_clk);
        #1 chk_idle("reset_after");

        foreach (tbl[k]) count_len(tbl[k], k);

        run_cmd(1, 1, 1, 4'd1, 0, 32'h0, -1, "full");
        run_cmd(0, 1, 0, 4'd0, 0, 32'h3, -1, "stall");
        run_cmd(1, 1, 1, 4'd3, 0, 32'h0, ZEN ? 3 : 2, "abort");
        run_cmd(1, 1, 1, 4'd3, 0, 32'h1, 0, "abort_stall");
        run_cmd(0, 1, 0, 4'd0, 0, 32'h0, 1, "abort_last");
        run_cmd(0, 0, 0, 4'd5, 0, 32'h0, -1, "empty");
        run_cmd(0, 0, 1, 4'd0, 0, 32'h0, -1, "gz_only");

        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_srcadd = 1'b1; cmd_gourd = 1'b0; cmd_gourz = 1'b0; cmd_count = 4'd0;
        for (int k = 0; k < 6; k++) begin
            #1 ld_v[k] = dadd_ld;
            rdy_v[k] = cmd_ready;
            @(negedge sys_clk);
        end
        cmd_valid = 1'b0;
        chk("b2b_ld", 16'(ld_v), 16'b101010);
        chk("b2b_ready", 16'(rdy_v), 16'b010101);

        accept(1, 1, 0, 4'd3, 1'b0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        #1 chk_idle("reset_mid");
        reset = 1'b0;
        @(negedge sys_clk);
        #1 chk_idle("reset_mid_after");

        for (int r = 0; r < 40; r++)
            run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
                    25, 32'h0, ($urandom_range(3) == 0) ? int'($urandom_range(0, 20)) : -1,
                    $sformatf("rnd%0d", r));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
